// File: rtl/xbar_pkg.sv
// Shared widths and FSM state encoding for the crossbar sequencer.
package xbar_pkg;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 8;
    localparam int unsigned W_W   = 4;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned NW    = ROWS * COLS;
    localparam int unsigned CNT_W = $clog2(NW);
    localparam int unsigned IDX_W = $clog2(COLS);

    typedef enum logic [2:0] {
        StEmpty,
        StLoad,
        StCommit,
        StIdle,
        StCompute,
        StEmit
    } state_e;
endpackage

// File: rtl/xbar_result_ser.sv
// Result buffer: captures all column sums in one cycle, then streams one column per beat.
// Optional XBAR_SAT_EN clamps each emitted value to 255.
module xbar_result_ser
    import xbar_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap,
    input  logic [COLS*SUM_W-1:0] sum_in,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [SUM_W-1:0]      m_data,
    output logic [IDX_W-1:0]      m_idx,
    output logic                  m_last,
    output logic                  done
);
    logic [SUM_W-1:0] res_q [COLS];
    logic [SUM_W-1:0] res_d [COLS];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [SUM_W-1:0] cur;
    logic             accept;
    logic             at_last;

    assign accept  = valid_q & m_ready;
    assign at_last = (idx_q == IDX_W'(COLS - 1));
    assign done    = accept & at_last;

    always_comb begin
        res_d   = res_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (cap) begin
            for (int j = 0; j < COLS; j++) begin
                res_d[j] = sum_in[j*SUM_W +: SUM_W];
            end
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (accept) begin
            // Index wraps to 0 after the last column, ready for the next capture.
            idx_d = idx_q + 1'b1;
            if (at_last) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '{default: '0};
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign cur = res_q[idx_q];

`ifdef XBAR_SAT_EN
    assign m_data = (cur > SUM_W'(255)) ? SUM_W'(255) : cur;
`else
    assign m_data = cur;
`endif

    assign m_valid = valid_q;
    assign m_idx   = idx_q;
    assign m_last  = valid_q & at_last;
endmodule

// File: rtl/xbar_sequencer.sv
// Crossbar sequencer: loads 32 weights into a shadow register, commits them with one write
// strobe, drives one input vector and streams the eight column sums. Macro: XBAR_SAT_EN.
module xbar_sequencer
    import xbar_pkg::*;
#(
    parameter int unsigned SUM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [W_W-1:0]        w_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [ROWS*W_W-1:0]   x_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [SUM_W-1:0]      m_data,
    output logic [IDX_W-1:0]      m_idx,
    output logic                  m_last,
    output logic                  xb_wren,
    output logic [NW*W_W-1:0]     xb_d,
    output logic [ROWS*W_W-1:0]   xb_r,
    input  logic [COLS*SUM_W-1:0] xb_sum,
    output logic                  busy
);
    localparam logic [CNT_W-1:0] LatLast  = CNT_W'(SUM_LAT - 1);
    localparam logic [CNT_W-1:0] BeatLast = CNT_W'(NW - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NW*W_W-1:0]    shadow_q, shadow_d;
    logic [ROWS*W_W-1:0]  row_q, row_d;
    logic                 wren_q, wren_d;
    logic                 w_ready_q, w_ready_d;
    logic                 x_open_q, x_open_d;
    logic                 busy_q, busy_d;
    logic                 w_fire, x_fire, cap, ser_done;

    assign w_fire  = w_valid & w_ready_q;
    // A pending weight beat takes priority over an input vector.
    assign x_ready = x_open_q & ~w_valid;
    assign x_fire  = x_valid & x_ready;
    assign cap     = (state_q == StCompute) && (cnt_q == LatLast);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        row_d    = row_q;
        if (w_fire) begin
            shadow_d[{cnt_q, 2'b00} +: W_W] = w_data;
        end
        unique case (state_q)
            StEmpty: begin
                if (w_fire) begin
                    state_d = StLoad;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StLoad: begin
                if (w_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BeatLast) begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: state_d = StIdle;
            StIdle: begin
                if (w_fire) begin
                    state_d = StLoad;
                    cnt_d   = cnt_q + 1'b1;
                end else if (x_fire) begin
                    state_d = StCompute;
                    row_d   = x_data;
                    cnt_d   = '0;
                end
            end
            StCompute: begin
                if (cap) begin
                    state_d = StEmit;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEmit: begin
                if (ser_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StEmpty;
        endcase

        wren_d    = (state_d == StCommit);
        w_ready_d = (state_d == StEmpty) || (state_d == StLoad) || (state_d == StIdle);
        x_open_d  = (state_d == StIdle);
        busy_d    = !((state_d == StEmpty) || (state_d == StIdle));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            cnt_q     <= '0;
            shadow_q  <= '0;
            row_q     <= '0;
            wren_q    <= 1'b0;
            w_ready_q <= 1'b0;
            x_open_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            row_q     <= row_d;
            wren_q    <= wren_d;
            w_ready_q <= w_ready_d;
            x_open_q  <= x_open_d;
            busy_q    <= busy_d;
        end
    end

    assign w_ready = w_ready_q;
    assign xb_wren = wren_q;
    assign xb_d    = shadow_q;
    assign xb_r    = row_q;
    assign busy    = busy_q;

    xbar_result_ser u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .cap     (cap),
        .sum_in  (xb_sum),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_idx   (m_idx),
        .m_last  (m_last),
        .done    (ser_done)
    );
endmodule

// File: tb/tb_xbar_sequencer.sv
// Bench: two sequencers (SUM_LAT 1 and 3) share stimulus; each drives a behavioural crossbar
// and its result stream is scoreboarded against sums derived from the bench's own weights.
module tb_xbar_sequencer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         w_valid, x_valid, m_ready;
    logic [3:0]   w_data;
    logic [15:0]  x_data;
    logic [1:0]   w_ready, x_ready, m_valid, m_last, xb_wren, busy;
    logic [11:0]  m_data [2];
    logic [2:0]   m_idx  [2];
    logic [127:0] xb_d   [2];
    logic [15:0]  xb_r   [2];
    logic [95:0]  xb_sum [2];

    logic [127:0] w_lat  [2];
    logic [15:0]  r_seen [2];
    int           age    [2];
    int           wren_cnt [2];
    int           beat_n [2];
    logic         hold   [2];
    logic [11:0]  pd     [2];
    logic [2:0]   pi     [2];
    logic         pl     [2];
    logic         armed  [2];
    int           tx_cyc;
    int           cyc = 0;
    int           eq0[$];
    int           eq1[$];
    logic         mr_toggle;
    int           n_checks = 0;
    int           n_err = 0;

    int W37 [32] = '{1, 2, 3, 4, 5, 6, 7, 1,  2, 3, 4, 5, 1, 1, 1, 1,
                     1, 2, 2, 2, 2, 2, 1, 1,  2, 3, 1, 5, 5, 5, 2, 1};
    int W15 [32] = '{default: 15};
    int LIT37 [8] = '{25, 41, 52, 69, 42, 47, 47, 16};

    always #5 clk = ~clk;

    xbar_sequencer #(.SUM_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready[0]), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready[0]), .x_data(x_data),
        .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]), .m_idx(m_idx[0]),
        .m_last(m_last[0]), .xb_wren(xb_wren[0]), .xb_d(xb_d[0]), .xb_r(xb_r[0]),
        .xb_sum(xb_sum[0]), .busy(busy[0])
    );

    xbar_sequencer #(.SUM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready[1]), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready[1]), .x_data(x_data),
        .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]), .m_idx(m_idx[1]),
        .m_last(m_last[1]), .xb_wren(xb_wren[1]), .xb_d(xb_d[1]), .xb_r(xb_r[1]),
        .xb_sum(xb_sum[1]), .busy(busy[1])
    );

    // Crossbar: column j sums r_i * w(i,j); weight (i,j) sits in nibble 8*i+j.
    function automatic logic [95:0] xsum(input logic [127:0] w, input logic [15:0] r);
        logic [95:0] s;
        int acc;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            acc = 0;
            for (int i = 0; i < 4; i++) begin
                acc += int'(r[4*i +: 4]) * int'(w[4*(8*i+j) +: 4]);
            end
            s[12*j +: 12] = 12'(acc);
        end
        return s;
    endfunction

    // Sums read as garbage until xb_r has been stable for SUM_LAT-1 full cycles.
    assign xb_sum[0] = xsum(w_lat[0], xb_r[0]);
    assign xb_sum[1] = (age[1] >= 2) ? xsum(w_lat[1], xb_r[1]) : '1;

    function automatic int sat(input int v);
`ifdef XBAR_SAT_EN
        return (v > 255) ? 255 : v;
`else
        return v;
`endif
    endfunction

    function automatic int exp_col(input int w[32], input int r[4], input int j);
        int s = 0;
        for (int i = 0; i < 4; i++) s += r[i] * w[8*i + j];
        return s;
    endfunction

    task automatic check(input string name, input int k, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic check_m(input int k);
        int e;
        if (!rst_n) begin
            hold[k]   = 1'b0;
            armed[k]  = 1'b0;
            beat_n[k] = 0;
            return;
        end
        if (armed[k] && m_valid[k]) begin
            check("first_m_latency", k, cyc - tx_cyc, (k == 0) ? 2 : 4);
            armed[k] = 1'b0;
        end
        if (hold[k]) begin
            check("hold_valid", k, m_valid[k], 1);
            check("hold_data", k, m_data[k], pd[k]);
            check("hold_idx", k, m_idx[k], pi[k]);
            check("hold_last", k, m_last[k], pl[k]);
        end
        if (m_valid[k] && m_ready) begin
            if ((k == 0) ? (eq0.size() == 0) : (eq1.size() == 0)) begin
                check("unexpected_beat", k, m_valid[k], 0);
            end else begin
                if (k == 0) e = eq0.pop_front();
                else        e = eq1.pop_front();
                check("m_data", k, m_data[k], e);
                check("m_idx", k, m_idx[k], beat_n[k] % 8);
                check("m_last", k, m_last[k], (beat_n[k] % 8) == 7);
                beat_n[k]++;
            end
        end
        hold[k] = m_valid[k] && !m_ready;
        pd[k] = m_data[k];
        pi[k] = m_idx[k];
        pl[k] = m_last[k];
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            w_lat[k] = '0; r_seen[k] = '0; age[k] = 0; wren_cnt[k] = 0;
            beat_n[k] = 0; hold[k] = 1'b0; armed[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (xb_wren[k]) begin
                    w_lat[k] = xb_d[k];
                    wren_cnt[k]++;
                end
                if (xb_r[k] != r_seen[k]) begin
                    r_seen[k] = xb_r[k];
                    age[k] = 0;
                end else if (age[k] < 15) begin
                    age[k]++;
                end
                check_m(k);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = mr_toggle ? ~m_ready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check_reset();
        for (int k = 0; k < 2; k++) begin
            check("rst_w_ready", k, w_ready[k], 0);
            check("rst_x_ready", k, x_ready[k], 0);
            check("rst_m_valid", k, m_valid[k], 0);
            check("rst_m_last", k, m_last[k], 0);
            check("rst_xb_wren", k, xb_wren[k], 0);
            check("rst_xb_d", k, xb_d[k], 0);
            check("rst_xb_r", k, xb_r[k], 0);
            check("rst_busy", k, busy[k], 0);
        end
    endtask

    task automatic send_w(input logic [3:0] d);
        int n = 0;
        w_valid = 1'b1;
        w_data  = d;
        @(negedge clk);
        while (!(w_ready[0] && w_ready[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("w_timeout", 0, w_ready, 2'b11);
        @(posedge clk);
        #1;
        w_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(x_ready[0] && x_ready[1]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 0, n < 20, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int w[32], input int start);
        int c0 [2];
        c0[0] = wren_cnt[0];
        c0[1] = wren_cnt[1];
        for (int b = start; b < 32; b++) begin
            send_w(4'(w[b]));
            for (int k = 0; k < 2; k++) begin
                check("x_ready_in_load", k, x_ready[k], 0);
                if (b == 16) check("busy_in_load", k, busy[k], 1);
                if (b == 31) begin
                    check("wren_at_commit", k, xb_wren[k], 1);
                    check("no_early_wren", k, wren_cnt[k] - c0[k], 0);
                end
            end
        end
        wait_idle();
        for (int k = 0; k < 2; k++) check("one_wren", k, wren_cnt[k] - c0[k], 1);
    endtask

    task automatic send_x(input logic [15:0] r);
        int n = 0;
        x_valid = 1'b1;
        x_data  = r;
        @(negedge clk);
        while (!(x_ready[0] && x_ready[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("x_timeout", 0, x_ready, 2'b11);
        tx_cyc   = cyc;
        armed[0] = 1'b1;
        armed[1] = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [15:0] r);
        int n = 0;
        while (!(eq0.size() == 0 && eq1.size() == 0 && !busy[0] && !busy[1]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("emit_timeout", 0, n < 300, 1);
        for (int k = 0; k < 2; k++) check("xb_r_held", k, xb_r[k], r);
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v);
        eq0.push_back(v);
        eq1.push_back(v);
    endtask

    initial begin
        int r4 [4];
        int c0 [2];
        rst_n = 1'b1; w_valid = 1'b0; x_valid = 1'b0; w_data = '0; x_data = '0;
        mr_toggle = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("w_ready_after_rst", k, w_ready[k], 1);
            check("x_ready_after_rst", k, x_ready[k], 0);
        end

        // Reference weights, x = r1..r4 = 5,8,2,1, m_ready held high.
        load(W37, 0);
        for (int j = 0; j < 8; j++) push_exp(sat(LIT37[j]));
        send_x(16'h1285);
        wait_done(16'h1285);

        // Same vector with m_ready toggling every cycle.
        mr_toggle = 1'b1;
        for (int j = 0; j < 8; j++) push_exp(sat(LIT37[j]));
        send_x(16'h1285);
        wait_done(16'h1285);
        mr_toggle = 1'b0;

        // Weight and x beats together in IDLE: weight wins, x_ready drops at once.
        w_valid = 1'b1;
        w_data  = 4'(W15[0]);
        x_valid = 1'b1;
        x_data  = 16'h3333;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("x_ready_w_priority", k, x_ready[k], 0);
            check("w_ready_w_priority", k, w_ready[k], 1);
        end
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        x_valid = 1'b0;
        load(W15, 1);

        // Full-scale weights and inputs.
        for (int j = 0; j < 8; j++) push_exp(sat(900));
        send_x(16'hFFFF);
        wait_done(16'hFFFF);

        // Reset after 17 beats of a reload; everything must be reloaded.
        c0[0] = wren_cnt[0];
        c0[1] = wren_cnt[1];
        for (int b = 0; b < 17; b++) send_w(4'(W37[b]));
        rst_n = 1'b0;
        eq0.delete();
        eq1.delete();
        @(negedge clk);
        check_reset();
        for (int k = 0; k < 2; k++) check("no_wren_partial", k, wren_cnt[k] - c0[k], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check("x_ready_after_rst2", k, x_ready[k], 0);
        load(W37, 0);
        r4 = '{1, 2, 3, 4};
        for (int j = 0; j < 8; j++) push_exp(sat(exp_col(W37, r4, j)));
        send_x(16'h4321);
        wait_done(16'h4321);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
